// File: rtl/prbs15_checker.sv
// prbs15_checker: verifies a repeated pattern preamble, then self-syncs and checks a PRBS-15 byte stream
module prbs15_checker #(
  parameter int patt_width   = 8,
  parameter int patt_num     = 4,
  parameter int REPEAT_TIMES = 5,
  parameter int LOSS_THRESH  = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [REPEAT_TIMES-1:0]        n,
  input  logic [patt_width*patt_num-1:0] Pattern,
  input  logic [patt_width-1:0]          byte_in,
  input  logic                           byte_valid,
  input  logic                           clr_cnt,
  output logic                           patt_done,
  output logic                           patt_err,
  output logic                           lock,
  output logic                           err,
  output logic [CNT_WIDTH-1:0]           err_cnt
);
  localparam int SW  = (patt_num > 1) ? $clog2(patt_num) : 1;
  localparam int BCW = REPEAT_TIMES + SW;
  localparam int LW  = $clog2(LOSS_THRESH + 1);
  typedef enum logic [1:0] {IDLE, PATT, SEED, CHECK} state_t;
  state_t                          state;
  logic [REPEAT_TIMES-1:0]         n_q;
  logic [patt_width*patt_num-1:0]  pat_q;
  logic [BCW-1:0]                  bc;
  logic [SW-1:0]                   sel;
  logic                            seed_cnt;
  logic [14-patt_width:0]          seed_lo;
  logic [14:0]                     lfsr, lfsr_nx, l;
  logic [patt_width-1:0]           pred, exp_byte;
  logic [LW-1:0]                   consec;
  logic [BCW-1:0]                  last_b;
  logic                            e;
  assign exp_byte = pat_q[patt_width*(patt_num-1-int'(sel)) +: patt_width];
  assign last_b   = BCW'(patt_num * int'(n_q) - 1);
  assign e        = enable && state == CHECK && byte_valid && pred != byte_in;
  // predict the next byte's worth of PRBS-15 bits, MSB first, from the local LFSR
  always_comb begin
    l    = lfsr;
    pred = '0;
    for (int i = patt_width - 1; i >= 0; i--) begin
      pred[i] = l[14] ^ l[13];
      l       = {l[13:0], l[14] ^ l[13]};
    end
    lfsr_nx = l;
  end
  // checker state machine with registered status outputs and saturating error counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      n_q       <= '0;
      pat_q     <= '0;
      bc        <= '0;
      sel       <= '0;
      seed_cnt  <= 1'b0;
      seed_lo   <= '0;
      lfsr      <= '0;
      consec    <= '0;
      patt_done <= 1'b0;
      patt_err  <= 1'b0;
      lock      <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      patt_done <= 1'b0;
      err       <= e;
      err_cnt   <= clr_cnt ? CNT_WIDTH'(e) : (e && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;
      if (!enable) begin
        state <= IDLE;
        lock  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            n_q       <= n;
            pat_q     <= Pattern;
            patt_err  <= 1'b0;
            bc        <= '0;
            sel       <= '0;
            seed_cnt  <= 1'b0;
            consec    <= '0;
            state     <= (n != '0) ? PATT : SEED;
            patt_done <= (n == '0);
          end
          PATT: if (byte_valid) begin
            if (byte_in != exp_byte) patt_err <= 1'b1;
            bc  <= bc + 1'b1;
            sel <= (int'(sel) == patt_num - 1) ? '0 : sel + 1'b1;
            if (bc == last_b) begin
              state     <= SEED;
              patt_done <= 1'b1;
            end
          end
          SEED: if (byte_valid) begin
            seed_lo  <= byte_in[14-patt_width:0];
            seed_cnt <= ~seed_cnt;
            if (seed_cnt) begin
              lfsr  <= {seed_lo, byte_in};
              state <= CHECK;
              lock  <= 1'b1;
            end
          end
          CHECK: if (byte_valid) begin
            lfsr <= lfsr_nx;
            if (!e) consec <= '0;
            else if (int'(consec) == LOSS_THRESH - 1) begin
              consec <= '0;
              state  <= SEED;
              lock   <= 1'b0;
            end else consec <= consec + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_prbs15_checker.sv
// tb_prbs15_checker: randomized scoreboard bench for prbs15_checker against a bit-history model
module tb_prbs15_checker;
  localparam int CW = 6;
  typedef struct packed {logic pd, pe, lk, er; logic [CW-1:0] ec;} exp_t;
  logic clk = 1'b0, rst, enable, byte_valid, clr_cnt;
  logic [4:0] n;
  logic [31:0] Pattern;
  logic [7:0] byte_in;
  logic patt_done, patt_err, lock, err;
  logic [CW-1:0] err_cnt;
  int tests = 0, fails = 0;
  exp_t q[$];
  prbs15_checker #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .n(n), .Pattern(Pattern),
    .byte_in(byte_in), .byte_valid(byte_valid), .clr_cnt(clr_cnt),
    .patt_done(patt_done), .patt_err(patt_err), .lock(lock), .err(err), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  int m_mode, m_bc, m_sc, m_consec;
  logic [4:0] m_n;
  logic [31:0] m_p;
  bit hist[$];
  exp_t m;
  bit gs[$];
  int gpos;
  logic cur_en;
  logic [4:0] cur_n;
  logic [31:0] cur_p;
  task automatic model_step(input logic en, input logic [4:0] nn, input logic [31:0] pt,
                            input logic [7:0] b, input logic v, input logic c, input logic r);
    bit e;
    logic [7:0] pr;
    bit p;
    e = 0;
    m.pd = 0;
    if (r) begin
      m = '0;
      m_mode = 0; m_bc = 0; m_sc = 0; m_consec = 0; m_n = 0; m_p = 0;
      hist = {};
      repeat (15) hist.push_back(1'b0);
      return;
    end
    if (!en) m_mode = 0;
    else if (m_mode == 0) begin
      m_n = nn; m_p = pt; m.pe = 0; m_bc = 0; m_sc = 0; m_consec = 0;
      if (nn != 0) m_mode = 1;
      else begin m_mode = 2; m.pd = 1; end
    end else if (v) begin
      if (m_mode == 1) begin
        if (b != 8'((m_p >> (8 * (3 - m_bc % 4))) & 32'hFF)) m.pe = 1;
        m_bc++;
        if (m_bc == 4 * m_n) begin m_mode = 2; m.pd = 1; m_sc = 0; end
      end else if (m_mode == 2) begin
        for (int i = 7; i >= 0; i--) begin hist.push_back(b[i]); void'(hist.pop_front()); end
        m_sc++;
        if (m_sc == 2) m_mode = 3;
      end else begin
        pr = 0;
        for (int i = 0; i < 8; i++) begin
          p = hist[0] ^ hist[1];
          hist.push_back(p); void'(hist.pop_front());
          pr = {pr[6:0], p};
        end
        e = (pr != b);
        m_consec = e ? m_consec + 1 : 0;
        if (m_consec == 4) begin m_mode = 2; m_sc = 0; m_consec = 0; end
      end
    end
    m.er = e;
    m.lk = (m_mode == 3);
    if (c) m.ec = CW'(e);
    else if (e && m.ec != {CW{1'b1}}) m.ec = m.ec + 1'b1;
  endtask
  task automatic step(input logic [7:0] b, input logic v, input logic c, input logic r);
    @(negedge clk);
    rst = r; enable = cur_en; n = cur_n; Pattern = cur_p;
    byte_in = b; byte_valid = v; clr_cnt = c;
    model_step(cur_en, cur_n, cur_p, b, v, c, r);
    q.push_back(m);
  endtask
  task automatic send(input logic [7:0] b);
    repeat ($urandom_range(0, 1)) step(8'($urandom), 1'b0, 1'b0, 1'b0);
    step(b, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic gen_reset();
    gs = {};
    repeat (15) gs.push_back(1'b1);
    gpos = 0;
  endtask
  function automatic logic [7:0] gen_byte();
    logic [7:0] r;
    int k;
    for (int i = 0; i < 8; i++) begin
      k = gpos + i;
      while (gs.size() <= k) gs.push_back(gs[gs.size() - 15] ^ gs[gs.size() - 14]);
      r[7 - i] = gs[k];
    end
    gpos += 8;
    return r;
  endfunction
  task automatic send_patt(input int cnt, input int bad_idx, input logic [7:0] bad);
    for (int i = 0; i < cnt; i++)
      send(i == bad_idx ? bad : 8'(cur_p >> (8 * (3 - i % 4))));
  endtask
  task automatic start(input logic [4:0] nn, input logic [31:0] pt);
    cur_en = 0; step(8'h00, 1'b0, 1'b0, 1'b0);
    cur_en = 1; cur_n = nn; cur_p = pt; step(8'h00, 1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    exp_t x, a;
    forever begin
      @(posedge clk); #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        a = {patt_done, patt_err, lock, err, err_cnt};
        tests++;
        if (a !== x) begin
          fails++;
          $display("FAIL outputs t=%0t got pd=%b pe=%b lock=%b err=%b cnt=%0d want pd=%b pe=%b lock=%b err=%b cnt=%0d",
                   $time, a.pd, a.pe, a.lk, a.er, a.ec, x.pd, x.pe, x.lk, x.er, x.ec);
        end
      end
    end
  end
  initial begin
    cur_en = 0; cur_n = 0; cur_p = 0;
    repeat (3) step(8'h00, 1'b0, 1'b0, 1'b1);
    start(5'd2, 32'hA5C30F81);
    send_patt(8, -1, 8'h00);
    gen_reset(); repeat (20) send(gen_byte());
    start(5'd2, 32'hA5C30F81);
    send_patt(8, 2, 8'h0E);
    gen_reset(); repeat (20) send(gen_byte());
    start(5'd0, 32'h0);
    gen_reset();
    for (int i = 0; i < 200; i++) send(i == 50 ? gen_byte() ^ 8'h08 : gen_byte());
    repeat (4) send(~gen_byte());
    repeat (30) send(gen_byte());
    start(5'd31, $urandom);
    send_patt(124, -1, 8'h00);
    gen_reset(); repeat (10) send(gen_byte());
    repeat (400) step(8'($urandom), 1'($urandom), $urandom_range(0, 49) == 0, 1'b0);
    repeat (120) step(8'($urandom), 1'b1, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b1, 1'b0);
    repeat (150) step(8'($urandom), 1'b1, $urandom_range(0, 7) == 0, 1'b0);
    gen_reset(); repeat (6) send(gen_byte());
    repeat (2) send(8'($urandom));
    step(8'h00, 1'b0, 1'b0, 1'b1);
    repeat (3) step(8'($urandom), 1'b1, 1'b0, 1'b0);
    cur_en = 0; repeat (2) step(8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/prbs15_checker.md
Name: prbs15_checker

Overview:
- Receive-side checker for the pattern/PRBS-15 byte stream emitted by the team's PSBR generator.
- Verifies the fixed preamble first: the 32-bit Pattern repeated n times.
- Then self-synchronises a PRBS-15 LFSR from the received bytes and checks every following byte.
- Reports lock status, per-byte errors and a saturating error count. Sits at the link-receive end, downstream of the byte interface.

Parameters:
- patt_width, 8, bits per received byte.
- patt_num, 4, bytes per pattern word (Pattern is patt_width*patt_num bits).
- REPEAT_TIMES, 5, width of repeat count n.
- LOSS_THRESH, 4, consecutive errored bytes in CHECK that force resync.
- CNT_WIDTH, 16, error counter width.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- enable, input, 1, checker run; low forces IDLE on next edge.
- n, input, REPEAT_TIMES, preamble repeat count; sampled on IDLE exit.
- Pattern, input, patt_width*patt_num, preamble word; sampled on IDLE exit.
- byte_in, input, patt_width, received byte.
- byte_valid, input, 1, byte_in qualifier; a byte is consumed only when high.
- clr_cnt, input, 1, synchronous clear of err_cnt.
- patt_done, output, 1, one-cycle pulse when the preamble phase completes.
- patt_err, output, 1, sticky; a preamble byte mismatched; cleared on IDLE exit.
- lock, output, 1, high while in CHECK.
- err, output, 1, one-cycle pulse: consumed CHECK byte mismatched.
- err_cnt, output, CNT_WIDTH, total mismatched CHECK bytes, saturating.

Behaviour:
Reset:
- rst high on a clk edge: state=IDLE; all outputs 0; LFSR=0; counters=0.
- rst mid-operation aborts immediately. Reset has priority over every other input.

FSM states: IDLE, PATT, SEED, CHECK.
- IDLE: when enable=1, latch n and Pattern, clear patt_err, and set the byte/repeat counters to 0.
  - Next state is PATT if n!=0.
  - Next state is SEED if n==0; patt_done pulses on that transition.
- PATT: each valid byte is compared to the expected byte.
  - Expected byte order is MSB first: Pattern[31:24], [23:16], [15:8], [7:0], then repeat.
  - A mismatch sets patt_err. The preamble is not resynced; byte counting continues.
  - After byte patt_num*n is consumed, go to SEED and pulse patt_done on the same edge.
- SEED: consume 2 valid bytes, shifted in MSB first, giving 16 bits.
  - The LFSR is loaded with the last 15 bits received, with the newest bit in lfsr[0].
  - Go to CHECK on the edge that consumes the 2nd byte.
  - err/err_cnt are not affected.
- CHECK: PRBS-15 polynomial x^15+x^14+1.
  - Per bit: b = lfsr[14]^lfsr[13]; lfsr <= {lfsr[13:0], b}.
  - 8 bits are generated per consumed byte; the first generated bit is compared to byte_in[7].
  - The LFSR advances only on consumed bytes.
  - Mismatch (any bit): err pulses, err_cnt increments, and the consecutive-error counter increments.
  - A good byte clears the consecutive-error counter.
  - The LFSR always advances from its own prediction, not from received data.
  - When the consecutive-error counter reaches LOSS_THRESH: go to SEED, lock drops the next cycle, and the counter is cleared.
- enable=0 in any state: next state IDLE, lock=0. err_cnt holds, patt_err holds.

Timing:
- Latency: all outputs are registered. err, patt_done and lock reflect the byte consumed on edge k at edge k (visible in the cycle after the byte was presented).
- byte_valid=0 cycles: nothing advances; err=0.

Counter:
- err_cnt saturates at 2^CNT_WIDTH-1.
- clr_cnt together with an error on the same edge gives err_cnt=1 (clear, then count).
- clr_cnt alone gives 0.

Boundaries:
- n=0 skips PATT.
- n=31 gives 124 preamble bytes; the counters must hold 124 without wrap.
- Back-to-back valid bytes are supported at 1 byte/cycle.

Test Plan:
- Preamble, clean: Pattern=0xA5C30F81, n=2, bytes A5 C3 0F 81 A5 C3 0F 81 → patt_done pulses after the 8th byte; patt_err=0; state=SEED.
- Preamble error: same as above, but the 3rd byte is 0x0E → patt_err=1 (sticky), patt_done still pulses after byte 8, and the checker proceeds to SEED/CHECK.
- Lock and clean check: n=0, then 200 reference PRBS-15 bytes (seed 0x7FFF) → lock=1 after byte 2, err never pulses, err_cnt=0.
- Single error: in the locked stream, flip bit 3 of byte 50 → one err pulse, err_cnt=1, lock stays 1, the following bytes are clean.
- Loss of lock: while locked, inject 4 consecutive 0x00 bytes (non-matching), then clean PRBS → err_cnt=4, lock falls, relock after 2 bytes, err_cnt stays 4.
- Reset/control: rst asserted mid-CHECK → next cycle all outputs 0, state IDLE. clr_cnt with err_cnt=0xFFFF → 0. Saturation: force 0xFFFF plus one more error → stays 0xFFFF.
